prn_code_checker: RTL and testbench
===================================

Name: prn_code_checker

Overview:
- Receive-side counterpart of channel_shift_reg, the LFSR code generator: checks a serial PRN code chip stream against a locally predicted sequence.
- Self-seeds its model register from the received chips, verifies the seed, then flywheels. Counts chip errors per window, declares and drops lock, and reports code phase and epoch.
- Sits in the correlator loopback/self-test path, after the imitator's code output or after a demodulated chip slicer.

Parameters:
- SR_W, 32, model shift-register width; must equal the generator register width.
- PH_W, 32, width of the code-phase counter and prn_length.
- ERR_W, 16, width of the window and total error counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- code_bitmask  in  SR_W  feedback taps; same value programmed into the generator.
- prn_length  in  PH_W  code period in chips minus 1, e.g. 510 for a 511-chip code.
- verify_len  in  16  consecutive correct predictions required to lock; 0 is treated as 1.
- win_len  in  16  error-window length in chips minus 1.
- err_thresh  in  ERR_W  lock drops when window errors exceed this value.
- doinit  in  1  restart acquisition; level-sensitive, same role as in the generator.
- code_in  in  1  received chip.
- code_valid  in  1  chip strobe, one clk per chip, same role as shift in the generator.
- locked  out  1  lock indicator.
- state  out  2  0 IDLE, 1 FILL, 2 VERIFY, 3 LOCKED.
- code_phase  out  PH_W  chip index within the period.
- epoch  out  1  one-clk pulse when code_phase wraps to 0.
- win_err  out  ERR_W  error count of the last completed window.
- total_err  out  ERR_W  saturating error count since lock.
- pred_bit  out  1  current prediction.

Behaviour:
- Reset state: every output 0, state IDLE, model register r = 0.
- Every action below occurs only on a clk edge with code_valid = 1. All outputs are registered, so they reflect a chip one clk after its strobe.
- Prediction: pred = ^(r & code_bitmask). This holds for any generator output tap by linearity.
- IDLE: ignores chips. doinit = 1 moves to FILL.
- FILL:
  - r <= {r[SR_W-2:0], code_in}; fill_cnt increments per chip.
  - After SR_W chips, go to VERIFY with ok_cnt = 0.
- VERIFY:
  - Compare code_in with pred, then r <= {r[SR_W-2:0], pred} (flywheel).
  - Mismatch: return to FILL with fill_cnt = 0 and keep r shifting with code_in.
  - Match: ok_cnt increments. When ok_cnt reaches verify_len, go to LOCKED.
  - On entering LOCKED: locked = 1, code_phase = 0, total_err = 0, window cleared.
- LOCKED:
  - Flywheel r with pred; a received error never enters r.
  - Each mismatch increments the window counter and total_err; total_err saturates at all-ones.
  - code_phase increments per chip. At prn_length it wraps to 0 and epoch pulses that clk.
  - At window end (win_len + 1 chips): win_err = window count, then the window clears.
  - If window count > err_thresh: go to FILL and drop locked the same clk. win_err holds its last value.
- doinit = 1 in any state: go to FILL, clear fill_cnt, ok_cnt and window, locked = 0. doinit overrides a simultaneous code_valid, and that chip is discarded.
- Mismatch and window end on the same chip: the mismatch is counted in the closing window.
- Asynchronous reset mid-operation: returns to the reset state immediately; a doinit is needed to restart.

Optional Feature:
- Macro: EPOCH_RESYNC_EN.
- Defined (for truncated codes whose generator reloads at epoch):
  - On each epoch the block enters an internal refill sub-phase for SR_W chips, shifting code_in into r.
  - During the refill, comparisons are suppressed, no errors are counted, and locked stays 1.
  - code_phase keeps counting through the refill.
- Undefined: pure continuous flywheel across epochs.

Decomposition:
- State encodings and the refill constant go in the shared channel_param.v include, alongside the existing channel constants.
- Sub-module prn_err_window: window chip counter, error counter, win_err latch and threshold compare.

Test Plan:
- Bench generator with taps 32'h00000110 (x^9+x^5+1), prn_length 510, verify_len 16, after doinit -> locked = 1 after 32+16 chips; epoch every 511 chips.
- Locked; inject 3 errors within a 64-chip window (win_len 63, err_thresh 4) -> win_err = 3, locked stays 1, total_err = 3.
- Inject 6 errors in one window -> locked falls at that window end, state = FILL, relock after 48 clean chips.
- Error injected in the 5th VERIFY chip -> returns to FILL; locked never asserts.
- doinit asserted while LOCKED -> next clk state = FILL, locked = 0; asynchronous reset mid-FILL -> all outputs 0 immediately.
- EPOCH_RESYNC_EN defined, generator truncated and reloaded every 300 chips (prn_length 299) -> no errors counted and locked held; without the macro -> lock is lost after the first epoch.

Source files
------------

// File: rtl/prn_code_checker_pkg.sv
// Shared definitions for the PRN code checker: state encoding and the
// verify-length helper.
package prn_code_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } prn_state_e;

  localparam int unsigned VLEN_W = 16;
  localparam int unsigned WLEN_W = 16;

  // A verify length of zero behaves as one.
  function automatic logic [VLEN_W-1:0] eff_verify_len(input logic [VLEN_W-1:0] v);
    return (v == '0) ? VLEN_W'(1) : v;
  endfunction

endpackage

// File: rtl/prn_err_window.sv
// Error window for the PRN code checker: counts chips and errors over a
// window of (win_len + 1) chips, latches the closing count and flags a
// threshold violation at window end.
module prn_err_window
  import prn_code_checker_pkg::*;
#(
  parameter int unsigned ERR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_chip,
  input  logic              i_err,
  input  logic [WLEN_W-1:0] i_win_len,
  input  logic [ERR_W-1:0]  i_err_thresh,
  output logic [ERR_W-1:0]  o_win_err,
  output logic              o_drop
);

  logic [WLEN_W-1:0] r_chip_cnt;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [ERR_W-1:0]  r_win_err;
  logic [ERR_W-1:0]  w_err_next;
  logic              w_end;

  // An error on the closing chip still belongs to the closing window.
  assign w_err_next = (i_err && (r_err_cnt != '1)) ? r_err_cnt + ERR_W'(1) : r_err_cnt;
  assign w_end      = i_chip && (r_chip_cnt == i_win_len);
  assign o_drop     = w_end && (w_err_next > i_err_thresh);
  assign o_win_err  = r_win_err;

  // Window chip/error counters and end-of-window latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chip_cnt <= '0;
      r_err_cnt  <= '0;
      r_win_err  <= '0;
    end else if (i_clr) begin
      r_chip_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (i_chip) begin
      if (w_end) begin
        r_chip_cnt <= '0;
        r_err_cnt  <= '0;
        r_win_err  <= w_err_next;
      end else begin
        r_chip_cnt <= r_chip_cnt + WLEN_W'(1);
        r_err_cnt  <= w_err_next;
      end
    end
  end

endmodule

// File: rtl/prn_code_checker.sv
// PRN code checker: self-seeds a model LFSR from received chips, verifies
// the seed, then flywheels and monitors chip errors per window.
// Optional macro EPOCH_RESYNC_EN: refill the model from received chips for
// SR_W chips at the start of every code period (truncated codes).
module prn_code_checker
  import prn_code_checker_pkg::*;
#(
  parameter int unsigned SR_W  = 32,
  parameter int unsigned PH_W  = 32,
  parameter int unsigned ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SR_W-1:0]  code_bitmask,
  input  logic [PH_W-1:0]  prn_length,
  input  logic [15:0]      verify_len,
  input  logic [15:0]      win_len,
  input  logic [ERR_W-1:0] err_thresh,
  input  logic             doinit,
  input  logic             code_in,
  input  logic             code_valid,
  output logic             locked,
  output logic [1:0]       state,
  output logic [PH_W-1:0]  code_phase,
  output logic             epoch,
  output logic [ERR_W-1:0] win_err,
  output logic [ERR_W-1:0] total_err,
  output logic             pred_bit
);

  localparam int unsigned FILL_W = $clog2(SR_W);
  localparam int unsigned RF_W   = $clog2(SR_W + 1);

  prn_state_e        r_state, w_state_next;
  logic [SR_W-1:0]   r_sr, w_sr_next;
  logic [FILL_W-1:0] r_fill, w_fill_next;
  logic [15:0]       r_ok, w_ok_next;
  logic              r_locked, w_locked_next;
  logic [PH_W-1:0]   r_phase, w_phase_next;
  logic              r_epoch, w_epoch_next;
  logic [ERR_W-1:0]  r_total, w_total_next;
  logic              r_pred;
`ifdef EPOCH_RESYNC_EN
  logic [RF_W-1:0]   r_refill, w_refill_next;
`endif

  logic        w_pred, w_mis, w_cmp;
  logic [15:0] w_ok_inc;
  logic        w_verify_done;
  logic        w_win_chip, w_win_err, w_win_clr, w_drop;

  assign w_pred        = ^(r_sr & code_bitmask);
  assign w_mis         = code_in ^ w_pred;
  assign w_ok_inc      = r_ok + 16'd1;
  assign w_verify_done = (w_ok_inc == eff_verify_len(verify_len));
`ifdef EPOCH_RESYNC_EN
  assign w_cmp = (r_refill == '0);
`else
  assign w_cmp = 1'b1;
`endif
  assign w_win_chip = !doinit && code_valid && (r_state == ST_LOCKED);
  assign w_win_err  = w_win_chip && w_cmp && w_mis;
  assign w_win_clr  = doinit ||
                      (code_valid && (r_state == ST_VERIFY) && !w_mis && w_verify_done);

  prn_err_window #(.ERR_W(ERR_W)) u_win (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_win_clr),
    .i_chip       (w_win_chip),
    .i_err        (w_win_err),
    .i_win_len    (win_len),
    .i_err_thresh (err_thresh),
    .o_win_err    (win_err),
    .o_drop       (w_drop)
  );

  // Next-state and datapath updates for one received chip.
  always_comb begin
    w_state_next  = r_state;
    w_sr_next     = r_sr;
    w_fill_next   = r_fill;
    w_ok_next     = r_ok;
    w_locked_next = r_locked;
    w_phase_next  = r_phase;
    w_epoch_next  = 1'b0;
    w_total_next  = r_total;
`ifdef EPOCH_RESYNC_EN
    w_refill_next = r_refill;
`endif
    if (doinit) begin
      w_state_next  = ST_FILL;
      w_fill_next   = '0;
      w_ok_next     = '0;
      w_locked_next = 1'b0;
`ifdef EPOCH_RESYNC_EN
      w_refill_next = '0;
`endif
    end else if (code_valid) begin
      case (r_state)
        ST_FILL: begin
          w_sr_next = {r_sr[SR_W-2:0], code_in};
          if (r_fill == FILL_W'(SR_W - 1)) begin
            w_state_next = ST_VERIFY;
            w_fill_next  = '0;
            w_ok_next    = '0;
          end else begin
            w_fill_next = r_fill + FILL_W'(1);
          end
        end
        ST_VERIFY: begin
          if (w_mis) begin
            w_state_next = ST_FILL;
            w_fill_next  = '0;
            w_sr_next    = {r_sr[SR_W-2:0], code_in};
          end else begin
            w_sr_next = {r_sr[SR_W-2:0], w_pred};
            if (w_verify_done) begin
              w_state_next  = ST_LOCKED;
              w_locked_next = 1'b1;
              w_phase_next  = '0;
              w_total_next  = '0;
`ifdef EPOCH_RESYNC_EN
              // Lock entry starts a code period, so it arms the refill too.
              w_refill_next = RF_W'(SR_W);
`endif
            end else begin
              w_ok_next = w_ok_inc;
            end
          end
        end
        ST_LOCKED: begin
          w_sr_next = {r_sr[SR_W-2:0], w_pred};
`ifdef EPOCH_RESYNC_EN
          if (r_refill != '0) begin
            w_sr_next     = {r_sr[SR_W-2:0], code_in};
            w_refill_next = r_refill - RF_W'(1);
          end
`endif
          if (w_win_err && (r_total != '1)) w_total_next = r_total + ERR_W'(1);
          if (r_phase == prn_length) begin
            w_phase_next = '0;
            w_epoch_next = 1'b1;
`ifdef EPOCH_RESYNC_EN
            w_refill_next = RF_W'(SR_W);
`endif
          end else begin
            w_phase_next = r_phase + PH_W'(1);
          end
          if (w_drop) begin
            w_state_next  = ST_FILL;
            w_locked_next = 1'b0;
            w_fill_next   = '0;
            w_ok_next     = '0;
`ifdef EPOCH_RESYNC_EN
            w_refill_next = '0;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_sr     <= '0;
      r_fill   <= '0;
      r_ok     <= '0;
      r_locked <= 1'b0;
      r_phase  <= '0;
      r_epoch  <= 1'b0;
      r_total  <= '0;
      r_pred   <= 1'b0;
`ifdef EPOCH_RESYNC_EN
      r_refill <= '0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_sr     <= w_sr_next;
      r_fill   <= w_fill_next;
      r_ok     <= w_ok_next;
      r_locked <= w_locked_next;
      r_phase  <= w_phase_next;
      r_epoch  <= w_epoch_next;
      r_total  <= w_total_next;
      r_pred   <= ^(w_sr_next & code_bitmask);
`ifdef EPOCH_RESYNC_EN
      r_refill <= w_refill_next;
`endif
    end
  end

  assign locked     = r_locked;
  assign state      = r_state;
  assign code_phase = r_phase;
  assign epoch      = r_epoch;
  assign total_err  = r_total;
  assign pred_bit   = r_pred;

endmodule

// File: tb/tb_prn_code_checker.sv
// Testbench for prn_code_checker: table-driven acquisition/window steps with
// a scoreboard queue, plus hand sequences for doinit, epoch, reset and
// truncated-code behaviour.
`timescale 1ns/1ps
module tb_prn_code_checker;

  localparam logic [31:0] TAPS = 32'h0000_0110;
  localparam logic [31:0] SEED = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] code_bitmask;
  logic [31:0] prn_length;
  logic [15:0] verify_len;
  logic [15:0] win_len;
  logic [15:0] err_thresh;
  logic        doinit;
  logic        code_in;
  logic        code_valid;
  logic        locked;
  logic [1:0]  state;
  logic [31:0] code_phase;
  logic        epoch;
  logic [15:0] win_err;
  logic [15:0] total_err;
  logic        pred_bit;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] g;
  int unsigned gen_idx;
  int unsigned gen_period;

  typedef struct packed {
    logic [1:0]  st;
    logic        lk;
    logic [15:0] we;
    logic [15:0] te;
  } exp_t;

  typedef struct {
    string       name;
    bit          init;
    int unsigned n;
    int unsigned e0;
    int unsigned ne;
    exp_t        exp;
  } step_t;

  exp_t  sbq[$];
  step_t tbl[15];

  prn_code_checker #(.SR_W(32), .PH_W(32), .ERR_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .code_bitmask (code_bitmask),
    .prn_length   (prn_length),
    .verify_len   (verify_len),
    .win_len      (win_len),
    .err_thresh   (err_thresh),
    .doinit       (doinit),
    .code_in      (code_in),
    .code_valid   (code_valid),
    .locked       (locked),
    .state        (state),
    .code_phase   (code_phase),
    .epoch        (epoch),
    .win_err      (win_err),
    .total_err    (total_err),
    .pred_bit     (pred_bit)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference generator: Fibonacci LFSR emitting its newest bit.
  task automatic gen_chip(output logic b);
    if (gen_period != 0 && gen_idx == gen_period) begin
      g       = SEED;
      gen_idx = 0;
    end
    b = ^(g & TAPS);
    g = {g[30:0], b};
    gen_idx++;
  endtask

  task automatic send(input logic inv);
    logic b;
    gen_chip(b);
    @(negedge clk);
    code_in    = b ^ inv;
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
  endtask

  task automatic do_init();
    @(negedge clk);
    doinit     = 1'b1;
    code_valid = 1'b0;
    @(posedge clk);
    #1;
    doinit = 1'b0;
  endtask

  function automatic step_t mk(input string nm, input bit ini, input int unsigned n,
                               input int unsigned e0, input int unsigned ne,
                               input logic [1:0] st, input logic lk,
                               input logic [15:0] we, input logic [15:0] te);
    step_t s;
    s.name = nm; s.init = ini; s.n = n; s.e0 = e0; s.ne = ne;
    s.exp.st = st; s.exp.lk = lk; s.exp.we = we; s.exp.te = te;
    return s;
  endfunction

  task automatic run_step(input step_t s);
    exp_t e;
    if (s.init) do_init();
    for (int unsigned i = 0; i < s.n; i++) begin
      if (i == s.n - 1) sbq.push_back(s.exp);
      send(i >= s.e0 && i < s.e0 + s.ne);
    end
    if (sbq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.queue: got empty expected one entry", s.name);
    end else begin
      e = sbq.pop_front();
      check({s.name, ".state"},     32'(state),     32'(e.st));
      check({s.name, ".locked"},    32'(locked),    32'(e.lk));
      check({s.name, ".win_err"},   32'(win_err),   32'(e.we));
      check({s.name, ".total_err"}, 32'(total_err), 32'(e.te));
    end
  endtask

  initial begin
    int unsigned ep_cnt, ep_first, ep_second;
    bit          lost;

    reset = 1'b1; doinit = 1'b0; code_in = 1'b0; code_valid = 1'b0;
    code_bitmask = TAPS; prn_length = 32'd510; verify_len = 16'd16;
    win_len = 16'd63; err_thresh = 16'd4;
    g = SEED; gen_idx = 0; gen_period = 0;

    tbl[0]  = mk("fill32",     1'b1, 32, 0,  0, 2'd2, 1'b0, 16'd0, 16'd0);
    tbl[1]  = mk("verify15",   1'b0, 15, 0,  0, 2'd2, 1'b0, 16'd0, 16'd0);
    tbl[2]  = mk("lock",       1'b0, 1,  0,  0, 2'd3, 1'b1, 16'd0, 16'd0);
    tbl[3]  = mk("win1_open",  1'b0, 63, 40, 3, 2'd3, 1'b1, 16'd0, 16'd3);
    tbl[4]  = mk("win1_close", 1'b0, 1,  0,  0, 2'd3, 1'b1, 16'd3, 16'd3);
    tbl[5]  = mk("win2_open",  1'b0, 63, 5,  6, 2'd3, 1'b1, 16'd3, 16'd9);
    tbl[6]  = mk("win2_close", 1'b0, 1,  0,  0, 2'd1, 1'b0, 16'd6, 16'd9);
    tbl[7]  = mk("reacq47",    1'b0, 47, 0,  0, 2'd2, 1'b0, 16'd6, 16'd9);
    tbl[8]  = mk("relock",     1'b0, 1,  0,  0, 2'd3, 1'b1, 16'd6, 16'd0);
    tbl[9]  = mk("vf_fill",    1'b1, 32, 0,  0, 2'd2, 1'b0, 16'd6, 16'd0);
    tbl[10] = mk("vf_ok4",     1'b0, 4,  0,  0, 2'd2, 1'b0, 16'd6, 16'd0);
    tbl[11] = mk("vf_bad5",    1'b0, 1,  0,  1, 2'd1, 1'b0, 16'd6, 16'd0);
    tbl[12] = mk("vf_nolock",  1'b0, 40, 0,  0, 2'd2, 1'b0, 16'd6, 16'd0);
    tbl[13] = mk("lk_acq",     1'b1, 48, 0,  0, 2'd3, 1'b1, 16'd6, 16'd0);
    tbl[14] = mk("ep_acq",     1'b0, 48, 0,  0, 2'd3, 1'b1, 16'd6, 16'd0);

    repeat (3) @(posedge clk);
    #1;
    check("rst.state", 32'(state), 32'd0);
    check("rst.locked", 32'(locked), 32'd0);
    check("rst.phase", code_phase, 32'd0);
    check("rst.epoch", 32'(epoch), 32'd0);
    check("rst.win_err", 32'(win_err), 32'd0);
    check("rst.total_err", 32'(total_err), 32'd0);
    check("rst.pred_bit", 32'(pred_bit), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int unsigned i = 0; i < 14; i++) run_step(tbl[i]);

    // doinit while locked overrides a simultaneous chip
    @(negedge clk);
    doinit = 1'b1; code_valid = 1'b1; code_in = 1'b0;
    @(posedge clk);
    #1;
    doinit = 1'b0; code_valid = 1'b0;
    check("doinit_locked.state", 32'(state), 32'd1);
    check("doinit_locked.locked", 32'(locked), 32'd0);

    run_step(tbl[14]);
    check("phase_at_lock", code_phase, 32'd0);

    // epoch spacing over two full periods
    ep_cnt = 0; ep_first = 0; ep_second = 0;
    for (int unsigned i = 1; i <= 1022; i++) begin
      send(1'b0);
      if (i == 1) check("phase_after_1", code_phase, 32'd1);
      if (epoch) begin
        ep_cnt++;
        if (ep_cnt == 1) ep_first = i;
        else if (ep_cnt == 2) ep_second = i;
      end
    end
    check("epoch.count", ep_cnt, 32'd2);
    check("epoch.first", ep_first, 32'd511);
    check("epoch.second", ep_second, 32'd1022);
    check("epoch.total_err", 32'(total_err), 32'd0);
    check("epoch.locked", 32'(locked), 32'd1);

    // asynchronous reset in FILL
    do_init();
    repeat (10) send(1'b0);
    check("midfill.state", 32'(state), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst.state", 32'(state), 32'd0);
    check("async_rst.locked", 32'(locked), 32'd0);
    check("async_rst.phase", code_phase, 32'd0);
    check("async_rst.win_err", 32'(win_err), 32'd0);
    check("async_rst.total_err", 32'(total_err), 32'd0);
    check("async_rst.pred_bit", 32'(pred_bit), 32'd0);
    #2;
    reset = 1'b0;
    send(1'b0);
    check("after_rst_idle.state", 32'(state), 32'd0);

    // truncated code reloaded every 300 chips; lock lands on the last chip
    prn_length = 32'd299;
    g = SEED; gen_idx = 0; gen_period = 300;
    repeat (252) send(1'b0);
    check("trunc.idle_state", 32'(state), 32'd0);
    do_init();
    repeat (48) send(1'b0);
    check("trunc.locked", 32'(locked), 32'd1);
    lost = 1'b0;
    for (int unsigned i = 0; i < 600; i++) begin
      send(1'b0);
      if (!locked) lost = 1'b1;
    end
`ifdef EPOCH_RESYNC_EN
    check("trunc.lock_held", 32'(lost), 32'd0);
    check("trunc.total_err", 32'(total_err), 32'd0);
`else
    check("trunc.lock_lost", 32'(lost), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
